// File: rtl/mult_div_unit_pkg.sv
// Shared op encodings, FSM states and the 64-bit result helper for the
// multiply/divide unit; the controller decoder imports the same op codes.
package mult_div_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // commit=0 marks a result that must not reach HI/LO (divide by zero).
  typedef struct packed {
    logic        commit;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_result_t;

  function automatic mdu_result_t mdu_compute(input logic [OP_W-1:0] op,
                                              input logic [31:0]     a,
                                              input logic [31:0]     b);
    mdu_result_t r;
    logic [63:0] p;
    logic [31:0] ma, mb, q, rem;
    logic        sgn;
    r   = '0;
    p   = '0;
    q   = '0;
    rem = '0;
    sgn = (op == MDU_DIV);
    case (op)
      MDU_MULT: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r = '{commit: 1'b1, hi: p[63:32], lo: p[31:0]};
      end
      MDU_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        r = '{commit: 1'b1, hi: p[63:32], lo: p[31:0]};
      end
      MDU_DIV, MDU_DIVU: begin
        // Divide magnitudes, then restore signs: quotient truncates toward
        // zero, remainder follows the dividend. 0x80000000/-1 falls out as
        // 0x80000000 rem 0 without a special case.
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (mb != 32'd0) begin
          q   = ma / mb;
          rem = ma % mb;
          r.commit = 1'b1;
          r.lo     = (sgn && (a[31] ^ b[31])) ? -q : q;
          r.hi     = (sgn && a[31]) ? -rem : rem;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit holding architectural HI/LO. Mult/div results
// are computed at issue and committed after a fixed busy window.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            rd_sel,
  output logic            busy,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     rd_data
);

  localparam logic [5:0] MULT_CNT = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_CYCLES);

  mdu_state_e  state, state_next;
  logic [5:0]  cnt;
  mdu_result_t pend;
  logic        accept_md, accept_hi, accept_lo;

  // Any start while RUN is dropped, including moves to HI/LO.
  assign accept_md = start && (state == S_IDLE) && (op[2] == 1'b0);
  assign accept_hi = start && (state == S_IDLE) && (op == MDU_MTHI);
  assign accept_lo = start && (state == S_IDLE) && (op == MDU_MTLO);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept_md) state_next = S_RUN;
      S_RUN:  if (cnt == 6'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      pend <= '0;
    end else if (state == S_IDLE) begin
      if (accept_md) begin
        pend <= mdu_compute(op, a, b);
        cnt  <= op[1] ? DIV_CNT : MULT_CNT;
      end
      if (accept_hi) hi <= a;
      if (accept_lo) lo <= a;
    end else begin
      cnt <= cnt - 6'd1;
      if (cnt == 6'd1 && pend.commit) begin
        hi <= pend.hi;
        lo <= pend.lo;
      end
    end
  end

  assign busy    = (state == S_RUN);
  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of ops with hand-computed
// HI/LO and busy lengths, plus sequences for start-while-busy and reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_sel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, then count the cycles busy reads high (bounded).
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int  cyc;
    logic leak;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{MDU_DIVU,  32'h7,        32'h2,        32'h1,        32'h3,        10};
    vecs[4]  = '{MDU_MTHI,  32'h1111,     32'h0,        32'h1111,     32'h3,        0};
    vecs[5]  = '{MDU_MTLO,  32'h2222,     32'h0,        32'h1111,     32'h2222,     0};
    vecs[6]  = '{MDU_DIVU,  32'h5,        32'h0,        32'h1111,     32'h2222,     10};
    vecs[7]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    vecs[8]  = '{MDU_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
    vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};
    vecs[10] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[11] = '{3'd6,      32'hABCD,     32'h1,        32'hFFFFFFFE, 32'h00000001, 0};
    vecs[12] = '{MDU_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFFE, 32'h00000001, 10};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // rd_data mux follows rd_sel combinationally (hi=FFFFFFFE, lo=1)
    rd_sel = 1'b1; #1;
    check("rd_data_hi", rd_data, 32'hFFFFFFFE);
    rd_sel = 1'b0; #1;
    check("rd_data_lo", rd_data, 32'h00000001);

    // Starts while busy are ignored
    do_reset();
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40 && busy; i++) begin
      cyc = i;
      if (i == 2) begin
        start = 1'b1; op = MDU_MTLO; a = 32'hDEAD;
      end else if (i == 3) begin
        start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_ignore_cycles", 32'(cyc), 32'd5);
    check("busy_ignore_hi", hi, 32'h0);
    check("busy_ignore_lo", lo, 32'hC);
    rd_sel = 1'b1; #1;
    check("rd_data_hi_after_mult", rd_data, 32'h0);
    rd_sel = 1'b0; #1;
    check("rd_data_lo_after_mult", rd_data, 32'hC);

    // Reset mid-operation: no late commit
    run(MDU_MTHI, 32'h5, 32'h0, cyc);
    run(MDU_MTLO, 32'h6, 32'h0, cyc);
    check("preload_hi", hi, 32'h5);
    check("preload_lo", lo, 32'h6);
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_busy_c4", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop_busy", {31'd0, busy}, 32'h0);
    check("midop_hi", hi, 32'h0);
    check("midop_lo", lo, 32'h0);
    leak = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy || hi != 32'h0 || lo != 32'h0) leak = 1'b1;
    end
    check("midop_no_late_commit", {31'd0, leak}, 32'h0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = MDU_MTHI; a = 32'h77;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_vs_start_hi", hi, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
